// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the shared RW_Memory: picks fetch or
// load/store, issues a single strobe, waits out the read latency and returns data.
module mem_arbiter #(
    parameter int READ_LAT = 1,
    parameter int ARB_MODE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_store,
    output logic        mem_load,
    input  logic [31:0] mem_read_data,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state, state_nx;
    logic        grant_fetch;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  cnt;
    logic        last_fetch;

    logic        any_req;
    logic        pick_fetch;
    logic [31:0] sel_addr;
    logic        sel_we;
    logic        sel_mis;

    // Fetch wins when alone, or on a tie in round-robin mode if data went last.
    always_comb begin
        any_req    = if_req | d_req;
        pick_fetch = (if_req & ~d_req) |
                     (if_req & d_req & (ARB_MODE == 1) & ~last_fetch);
        sel_addr   = pick_fetch ? if_addr : d_addr;
        sel_we     = pick_fetch ? 1'b0 : d_we;
        sel_mis    = (sel_addr[1:0] != 2'b00);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (any_req) state_nx = sel_mis ? DONE : ISSUE;
            ISSUE: state_nx = we_q ? DONE : WAIT;
            WAIT:  if (cnt == 3'd1) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_fetch <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            last_fetch  <= 1'b1;
            if_rdata    <= '0;
            if_err      <= 1'b0;
            d_rdata     <= '0;
            d_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_fetch <= pick_fetch;
                        addr_q      <= sel_addr;
                        we_q        <= sel_we;
                        wdata_q     <= d_wdata;
                        last_fetch  <= pick_fetch;
                        // A misaligned winner completes with err set and zeroed data.
                        if (pick_fetch) begin
                            if_err <= sel_mis;
                            if (sel_mis) if_rdata <= '0;
                        end else begin
                            d_err <= sel_mis;
                            if (sel_mis) d_rdata <= '0;
                        end
                    end
                end
                ISSUE: cnt <= 3'(READ_LAT);
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (grant_fetch) if_rdata <= mem_read_data;
                        else             d_rdata  <= mem_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_load       = (state == ISSUE) & ~we_q;
        mem_store      = (state == ISSUE) & we_q;
        mem_address    = ((state == ISSUE) || (state == WAIT)) ? addr_q : '0;
        mem_write_data = mem_store ? wdata_q : '0;
        if_ready       = (state == DONE) & grant_fetch;
        d_ready        = (state == DONE) & ~grant_fetch;
        busy           = (state != IDLE);
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter/sequencer in front of the shared RW_Memory in the multi-cycle RISC-V CPU.
- Arbitrates between the instruction-fetch requester and the load/store requester.
- Generates the one-cycle mem_load/mem_store strobes, waits the memory read latency and returns data with a ready pulse.
- Rejects misaligned word accesses without touching memory.

Parameters:
- READ_LAT, 1, cycles from the mem_load strobe cycle until mem_read_data is valid; legal range 1..4.
- ARB_MODE, 1, 0 = fixed priority (data port wins ties), 1 = round-robin between ports.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset: 0 = in reset.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  32  fetch byte address.
- if_ready  out  1  one-cycle completion pulse to fetch.
- if_rdata  out  32  fetched word; held until the next fetch grant.
- if_err  out  1  misaligned fetch flag; valid with if_ready.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_ready  out  1  one-cycle completion pulse to the data port.
- d_rdata  out  32  load result; held until the next data grant.
- d_err  out  1  misaligned data-access flag; valid with d_ready.
- mem_address  out  32  to RW_Memory address.
- mem_write_data  out  32  to RW_Memory write_data.
- mem_store  out  1  to RW_Memory mem_store.
- mem_load  out  1  to RW_Memory mem_load.
- mem_read_data  in  32  from RW_Memory read_data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0), asynchronous:
  - state = IDLE.
  - All outputs 0: mem_*, *_ready, *_rdata, *_err, busy.
  - Round-robin pointer = "fetch granted last", so the data port wins the first tie.
  - Applies mid-transaction: an in-flight access is abandoned, no ready is issued, and strobes drop immediately.
- IDLE:
  - On a clock edge with any req high, choose a winner and latch grant, address, we and wdata. Requests seen in any other state are ignored.
  - Both req high: ARB_MODE=0 gives data; ARB_MODE=1 gives the port not granted last.
  - The pointer updates only on a grant.
- Misaligned address (addr[1:0] != 0):
  - Next state DONE directly; no memory strobe.
  - Winner gets err=1 and rdata=0.
- ISSUE (exactly 1 cycle):
  - mem_address = latched address.
  - Store: mem_store=1 and mem_write_data=wdata, then next state DONE.
  - Load/fetch: mem_load=1, latency counter := READ_LAT, then next state WAIT.
- WAIT:
  - Strobes low, mem_address held.
  - Counter decrements each cycle.
  - On the cycle it reaches 1, mem_read_data is captured into the winner's rdata register at that edge; next state DONE.
- DONE (1 cycle):
  - Winner's ready=1; err=0 unless misaligned.
  - Next state IDLE.
  - Requester drops req on the same edge it samples ready, so IDLE sees req low. A req still high in IDLE is a new request.
- Latency, counted from the accepting edge:
  - Aligned store: ready in cycle 2.
  - Aligned load/fetch: ready in cycle READ_LAT+2.
  - Misaligned: ready in cycle 1.
- Strobe rules:
  - mem_store and mem_load are never high together.
  - At most one strobe cycle per transaction.
- rdata/err hold:
  - The non-winning port's rdata and err are untouched.
  - err clears on the next grant to that port.
- Stores leave d_rdata unchanged.
- Changes to addr/wdata after acceptance have no effect.

Test Plan:
- Reset held 0 with if_req=1 and d_req=1 → all outputs 0, no strobes; on release with both req high and ARB_MODE=1 → data granted first.
- Store then load (READ_LAT=1):
  - d_we=1, d_addr=0x04, d_wdata=0xDEADBEEF → one-cycle mem_store at address 0x04, d_ready in cycle 2.
  - Then d_we=0, d_addr=0x04 → d_ready in cycle 3, d_rdata=0xDEADBEEF.
- Contention, ARB_MODE=1:
  - if_addr=0x08 (preloaded 0x12345678) and d_addr=0x04 both held → grants alternate data, fetch, data.
  - if_rdata=0x12345678 and d_rdata=0xDEADBEEF.
  - ARB_MODE=0 → data always first.
- Misaligned: d_addr=0x06 load → no mem_load/mem_store, d_ready and d_err=1 in cycle 1, d_rdata=0; next aligned load clears d_err.
- Latency sweep, READ_LAT=3: fetch at 0x04 → mem_load for exactly 1 cycle, if_ready in cycle 5, if_rdata=0xDEADBEEF.
- Mid-transaction reset: reset=0 during WAIT of a load → strobes and ready stay 0, state IDLE. After release, the reissued load completes normally with the correct data.
